// File: rtl/text_pkg.sv
// text_pkg: shared widths, fill code and FSM encodings
// for the text-buffer arbiter and its write queue.
package text_pkg;

  localparam int DEF_ADDR_WIDTH  = 8;
  localparam int DEF_DATA_WIDTH  = 8;
  localparam int DEF_QUEUE_DEPTH = 4;

  localparam logic [7:0] DEF_CLEAR_CHAR = 8'h20;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_CLR_WAIT = 2'd1;
  localparam logic [1:0] ST_CLEAR    = 2'd2;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_DISP,
    GNT_CLR,
    GNT_WR
  } grant_e;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: small power-of-2 FIFO holding queued keyboard
// writes; a push while full is refused even if a pop occurs.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_head,
  output logic             o_full,
  output logic             o_empty,
  output logic [PW:0]      o_count
);

  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);
  localparam logic [PW:0] ONE_CNT  = (PW+1)'(1);
  localparam logic [PW-1:0] ONE_PTR = PW'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [PW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == FULL_CNT);
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_head  = r_mem[r_rptr];
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;

  // storage: entries need no reset, occupancy says what is live
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_din;
  end

  // pointers and occupancy, wrapping modulo their widths
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + ONE_PTR;
      if (w_pop)  r_rptr <= r_rptr + ONE_PTR;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + ONE_CNT;
        2'b01:   r_count <= r_count - ONE_CNT;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/text_buffer_arbiter.sv
// text_buffer_arbiter: shares one single-port text RAM between
// display reads, a whole-buffer clear and queued keyboard writes.
module text_buffer_arbiter
  import text_pkg::*;
#(
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int QUEUE_DEPTH = DEF_QUEUE_DEPTH,
  parameter logic [DATA_WIDTH-1:0] CLEAR_CHAR = DEF_CLEAR_CHAR
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  disp_req,
  input  logic [ADDR_WIDTH-1:0] disp_addr,
  output logic [DATA_WIDTH-1:0] disp_data,
  output logic                  disp_valid,
  input  logic                  wr_req,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_ready,
  input  logic                  clr_req,
  output logic                  clr_busy,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_wEn,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout
);

  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int EW = ADDR_WIDTH + DATA_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;
  localparam logic [ADDR_WIDTH-1:0] ONE_ADDR  = ADDR_WIDTH'(1);
  localparam logic [PW:0] ONE_CNT = (PW+1)'(1);

  logic [1:0]            r_state;
  logic [ADDR_WIDTH-1:0] r_clr_cnt;
  logic [PW:0]           r_drain;
  logic                  r_disp_valid;

  grant_e                w_grant;
  logic                  w_pop;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_wr_ok;
  logic [PW:0]           w_count;
  logic [EW-1:0]         w_head;
  logic [ADDR_WIDTH-1:0] w_head_addr;
  logic [DATA_WIDTH-1:0] w_head_data;

  assign w_head_addr = w_head[EW-1:DATA_WIDTH];
  assign w_head_data = w_head[DATA_WIDTH-1:0];

  sync_fifo #(
    .WIDTH (EW),
    .DEPTH (QUEUE_DEPTH)
  ) u_wq (
    .clk     (clk),
    .rst     (reset),
    .i_push  (wr_req),
    .i_pop   (w_pop),
    .i_din   ({wr_addr, wr_data}),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // in CLR_WAIT only entries queued before the clear may drain;
  // later ones wait so they land on top of the cleared buffer
  assign w_wr_ok = ~w_empty &
                   ((r_state == ST_IDLE) |
                    ((r_state == ST_CLR_WAIT) & (r_drain != '0)));

  // strict priority: display read, clear write, queued write
  always_comb begin
    w_grant = GNT_NONE;
    priority case (1'b1)
      disp_req:               w_grant = GNT_DISP;
      (r_state == ST_CLEAR):  w_grant = GNT_CLR;
      w_wr_ok:                w_grant = GNT_WR;
      default:                w_grant = GNT_NONE;
    endcase
  end

  assign w_pop = (w_grant == GNT_WR);

  // RAM port mux; reads and idle cycles present disp_addr
  always_comb begin
    ram_addr = disp_addr;
    ram_wEn  = 1'b0;
    ram_din  = '0;
    case (w_grant)
      GNT_CLR: begin
        ram_addr = r_clr_cnt;
        ram_wEn  = 1'b1;
        ram_din  = CLEAR_CHAR;
      end
      GNT_WR: begin
        ram_addr = w_head_addr;
        ram_wEn  = 1'b1;
        ram_din  = w_head_data;
      end
      default: ;
    endcase
  end

  // clear FSM: snapshot pre-clear backlog, drain it, then sweep
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_clr_cnt <= '0;
      r_drain   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (clr_req) begin
            r_state <= ST_CLR_WAIT;
            r_drain <= w_count - {{PW{1'b0}}, w_pop};
          end
        end
        ST_CLR_WAIT: begin
          if (r_drain == '0) r_state <= ST_CLEAR;
          else if (w_pop)    r_drain <= r_drain - ONE_CNT;
        end
        ST_CLEAR: begin
          if (w_grant == GNT_CLR) begin
            r_clr_cnt <= r_clr_cnt + ONE_ADDR;
            if (r_clr_cnt == LAST_ADDR) r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // read strobe trails the request by the RAM's one-cycle latency
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_disp_valid <= 1'b0;
    else       r_disp_valid <= disp_req;
  end

  assign disp_valid = r_disp_valid;
  assign disp_data  = r_disp_valid ? ram_dout : '0;
  assign clr_busy   = (r_state != ST_IDLE);
  assign wr_ready   = ~w_full;

endmodule

// File: tb/tb_text_buffer_arbiter.sv
// tb_text_buffer_arbiter: directed scenarios plus a random phase
// checked against a queue/memory level reference model.
module tb_text_buffer_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       disp_req;
  logic [7:0] disp_addr;
  logic [7:0] disp_data;
  logic       disp_valid;
  logic       wr_req;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       wr_ready;
  logic       clr_req;
  logic       clr_busy;
  logic [7:0] ram_addr;
  logic       ram_wEn;
  logic [7:0] ram_din;
  logic [7:0] ram_dout;

  typedef struct { int c; logic [7:0] a; logic [7:0] d; } wr_t;
  typedef struct { logic [7:0] a; logic [7:0] d; } ent_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0] ram [256];
  wr_t        wlog [$];
  logic [7:0] exp_mem [256];
  bit         known [256];

  text_buffer_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .disp_req   (disp_req),
    .disp_addr  (disp_addr),
    .disp_data  (disp_data),
    .disp_valid (disp_valid),
    .wr_req     (wr_req),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .clr_req    (clr_req),
    .clr_busy   (clr_busy),
    .ram_addr   (ram_addr),
    .ram_wEn    (ram_wEn),
    .ram_din    (ram_din),
    .ram_dout   (ram_dout)
  );

  always #5 clk = ~clk;

  // behavioural single-port RAM plus a log of every write
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ram_wEn) begin
      ram[ram_addr] <= ram_din;
      wlog.push_back('{cyc, ram_addr, ram_din});
    end
    ram_dout <= ram[ram_addr];
  end

  initial begin
    #1000000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic quiet();
    disp_req  = 1'b0;
    disp_addr = 8'h00;
    wr_req    = 1'b0;
    wr_addr   = 8'h00;
    wr_data   = 8'h00;
    clr_req   = 1'b0;
  endtask

  initial begin
    ent_t       q [$];
    ent_t       e;
    int         bad;
    int         n;
    int         c_done;
    int         hit;
    logic       prev_req;
    logic       prev_known;
    logic [7:0] prev_exp;

    reset = 1'b1;
    quiet();

    // reset values
    nxt();
    #1;
    chk("rst_valid", 32'(disp_valid), 0);
    chk("rst_data", 32'(disp_data), 0);
    chk("rst_busy", 32'(clr_busy), 0);
    chk("rst_ready", 32'(wr_ready), 1);
    chk("rst_wen", 32'(ram_wEn), 0);
    nxt();
    reset = 1'b0;

    // display priority over a queued write
    nxt();
    wr_req = 1'b1; wr_addr = 8'h10; wr_data = 8'h5A;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin
        nxt();
        wr_req = 1'b0;
      end
      disp_req = 1'b1;
      disp_addr = 8'(8'h30 + i);
      #1;
      chk("prio_wen", 32'(ram_wEn), 0);
      chk("prio_addr", 32'(ram_addr), 32'(disp_addr));
      if (i > 0) chk("prio_valid", 32'(disp_valid), 1);
    end
    nxt();
    disp_req = 1'b0;
    #1;
    chk("prio_wr_wen", 32'(ram_wEn), 1);
    chk("prio_wr_addr", 32'(ram_addr), 32'h10);
    chk("prio_wr_din", 32'(ram_din), 32'h5A);
    chk("prio_valid_last", 32'(disp_valid), 1);
    nxt();
    #1;
    chk("prio_valid_end", 32'(disp_valid), 0);
    chk("prio_idle_wen", 32'(ram_wEn), 0);

    // queue full: 5 pushes under constant reads, 4 accepted
    disp_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      nxt();
      wr_req = 1'b1;
      wr_addr = 8'(8'h20 + i);
      wr_data = 8'(8'h60 + i);
      #1;
      chk("full_ready", 32'(wr_ready), (i < 4) ? 1 : 0);
    end
    nxt();
    wr_req = 1'b0;
    disp_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) nxt();
      #1;
      chk("full_drain_wen", 32'(ram_wEn), 1);
      chk("full_drain_addr", 32'(ram_addr), 32'(8'h20 + i));
      chk("full_drain_din", 32'(ram_din), 32'(8'h60 + i));
    end
    nxt();
    #1;
    chk("full_drain_stop", 32'(ram_wEn), 0);

    // clear with two writes queued
    disp_req = 1'b1;
    nxt();
    wr_req = 1'b1; wr_addr = 8'h40; wr_data = 8'h70;
    nxt();
    wr_addr = 8'h41; wr_data = 8'h71;
    nxt();
    wr_req = 1'b0; disp_req = 1'b0; clr_req = 1'b1;
    wlog.delete();
    nxt();
    clr_req = 1'b0;
    #1;
    chk("clr_busy_on", 32'(clr_busy), 1);
    c_done = -1;
    for (int k = 0; k < 400; k++) begin
      nxt();
      #1;
      if (!clr_busy) begin
        c_done = cyc;
        break;
      end
    end
    chk("clr_finished", 32'(c_done >= 0), 1);
    chk("clr_count", 32'(wlog.size()), 258);
    if (wlog.size() >= 258) begin
      chk("clr_pre0", 32'({wlog[0].a, wlog[0].d}), 32'h4070);
      chk("clr_pre1", 32'({wlog[1].a, wlog[1].d}), 32'h4171);
      bad = 0;
      for (int i = 0; i < 256; i++)
        if (wlog[i+2].a !== 8'(i) || wlog[i+2].d !== 8'h20) bad++;
      chk("clr_sweep", 32'(bad), 0);
      chk("clr_busy_drop", 32'(c_done), 32'(wlog[257].c + 1));
    end
    for (int i = 0; i < 256; i++) begin
      exp_mem[i] = 8'h20;
      known[i] = 1'b1;
    end

    // clear with reads every other cycle and a write during it
    nxt();
    clr_req = 1'b1;
    wlog.delete();
    nxt();
    clr_req = 1'b0;
    prev_req = 1'b0;
    c_done = -1;
    for (int k = 0; k < 1200; k++) begin
      nxt();
      disp_req = k[0];
      disp_addr = 8'($urandom);
      wr_req = (k == 40);
      wr_addr = 8'h05;
      wr_data = 8'h41;
      #1;
      chk("il_valid", 32'(disp_valid), 32'(prev_req));
      prev_req = disp_req;
      if (!clr_busy) begin
        c_done = cyc;
        break;
      end
    end
    chk("il_finished", 32'(c_done >= 0), 1);
    quiet();
    repeat (3) nxt();
    chk("il_count", 32'(wlog.size()), 257);
    if (wlog.size() >= 257) begin
      bad = 0;
      for (int i = 0; i < 256; i++)
        if (wlog[i].a !== 8'(i) || wlog[i].d !== 8'h20) bad++;
      chk("il_sweep", 32'(bad), 0);
      chk("il_span", 32'(wlog[255].c - wlog[0].c), 510);
      chk("il_late_wr", 32'({wlog[256].a, wlog[256].d}), 32'h0541);
    end
    exp_mem[5] = 8'h41;
    nxt();
    disp_req = 1'b1;
    disp_addr = 8'h05;
    nxt();
    disp_req = 1'b0;
    #1;
    chk("il_read_valid", 32'(disp_valid), 1);
    chk("il_read_data", 32'(disp_data), 32'h41);

    // random reads and writes against the queue/memory model
    quiet();
    q.delete();
    prev_req = 1'b0;
    prev_known = 1'b0;
    prev_exp = 8'h00;
    for (int k = 0; k < 300; k++) begin
      nxt();
      disp_req  = 1'($urandom_range(0, 1));
      disp_addr = 8'($urandom);
      wr_req    = 1'($urandom_range(0, 1));
      wr_addr   = 8'($urandom);
      wr_data   = 8'($urandom);
      #1;
      chk("rnd_ready", 32'(wr_ready), 32'(q.size() < 4));
      if (disp_req) begin
        chk("rnd_rd_wen", 32'(ram_wEn), 0);
        chk("rnd_rd_addr", 32'(ram_addr), 32'(disp_addr));
      end else if (q.size() > 0) begin
        chk("rnd_wr_wen", 32'(ram_wEn), 1);
        chk("rnd_wr_addr", 32'(ram_addr), 32'(q[0].a));
        chk("rnd_wr_din", 32'(ram_din), 32'(q[0].d));
      end else begin
        chk("rnd_nil_wen", 32'(ram_wEn), 0);
        chk("rnd_nil_addr", 32'(ram_addr), 32'(disp_addr));
        chk("rnd_nil_din", 32'(ram_din), 0);
      end
      chk("rnd_valid", 32'(disp_valid), 32'(prev_req));
      if (prev_req && prev_known)
        chk("rnd_data", 32'(disp_data), 32'(prev_exp));
      n = q.size();
      prev_req = disp_req;
      prev_known = known[disp_addr];
      prev_exp = exp_mem[disp_addr];
      if (!disp_req && n > 0) begin
        e = q.pop_front();
        exp_mem[e.a] = e.d;
        known[e.a] = 1'b1;
      end
      if (wr_req && n < 4) q.push_back('{wr_addr, wr_data});
    end
    quiet();
    repeat (6) nxt();
    while (q.size() > 0) begin
      e = q.pop_front();
      exp_mem[e.a] = e.d;
    end
    bad = 0;
    for (int i = 0; i < 256; i++)
      if (ram[i] !== exp_mem[i]) bad++;
    chk("rnd_mem", 32'(bad), 0);

    // reset in the middle of a clear with a write queued
    nxt();
    clr_req = 1'b1;
    nxt();
    clr_req = 1'b0;
    hit = 0;
    for (int k = 0; k < 600; k++) begin
      nxt();
      wr_req = (k == 10);
      wr_addr = 8'h07;
      wr_data = 8'h99;
      #1;
      if (ram_wEn && ram_addr == 8'd99) begin
        hit = 1;
        break;
      end
    end
    chk("mid_reach", 32'(hit), 1);
    nxt();
    wr_req = 1'b0;
    disp_req = 1'b1;
    disp_addr = 8'h03;
    nxt();
    disp_req = 1'b0;
    #1;
    chk("mid_wen", 32'(ram_wEn), 1);
    chk("mid_addr", 32'(ram_addr), 100);
    chk("mid_valid", 32'(disp_valid), 1);
    reset = 1'b1;
    wlog.delete();
    #1;
    chk("arst_wen", 32'(ram_wEn), 0);
    chk("arst_busy", 32'(clr_busy), 0);
    chk("arst_ready", 32'(wr_ready), 1);
    chk("arst_valid", 32'(disp_valid), 0);
    chk("arst_data", 32'(disp_data), 0);
    nxt();
    nxt();
    reset = 1'b0;
    repeat (20) nxt();
    chk("arst_no_writes", 32'(wlog.size()), 0);
    chk("arst_busy_after", 32'(clr_busy), 0);
    chk("arst_ram99", 32'(ram[99]), 32'h20);
    chk("arst_ram7", 32'(ram[7]), 32'h20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
